// File: rtl/store_merge_pkg.sv
// store_merge_pkg
//
// Shared definitions for the read-modify-write store engine:
//   - state_t    : FSM state encoding (IDLE, READ, WRITE)
//   - SS_*       : store-size codes driven by the store-size stage
//   - CNT_W      : width of the memory read latency counter (MEM_LAT <= 7)

package store_merge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10
    } state_t;

    localparam logic [1:0] SS_WORD = 2'b00;
    localparam logic [1:0] SS_HALF = 2'b01;
    localparam logic [1:0] SS_BYTE = 2'b10;
    localparam logic [1:0] SS_RSVD = 2'b11;

    localparam int CNT_W = 3;

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge
//
// Purely combinational lane merge. Drops the low bits of the store value
// into the little-endian lane of the old memory word that is selected by
// the store size and the low address bits.
//
// Ports:
//   old_word  in  32  word read back from memory
//   data      in  32  right-aligned store value (bits beyond the lane ignored)
//   ss_ctrl   in  2   store size code (SS_WORD/SS_HALF/SS_BYTE/SS_RSVD)
//   addr_lo   in  2   addr[1:0] of the store
//   merged    out 32  old_word with the selected lane replaced

module store_lane_merge
    import store_merge_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  ss_ctrl,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    // Half stores only look at addr_lo[1]; a misaligned addr_lo[0] is
    // either rejected upstream or deliberately ignored here.
    always_comb begin
        merged = old_word;
        case (ss_ctrl)
            SS_WORD: merged = data;
            SS_HALF: begin
                if (addr_lo[1])
                    merged = {data[15:0], old_word[15:0]};
                else
                    merged = {old_word[31:16], data[15:0]};
            end
            SS_BYTE: begin
                case (addr_lo)
                    2'd0: merged = {old_word[31:8], data[7:0]};
                    2'd1: merged = {old_word[31:16], data[7:0], old_word[7:0]};
                    2'd2: merged = {old_word[31:24], data[7:0], old_word[15:0]};
                    default: merged = {data[7:0], old_word[23:0]};
                endcase
            end
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_merge.sv
// store_merge
//
// Read-modify-write store engine between the store-size stage and data
// memory. Word stores are written straight through; half and byte stores
// first read the enclosing word (MEM_LAT cycles), merge the new lane in and
// write the full word back, then pulse done.
//
// Build option: define STORE_MERGE_ALIGN_CHECK_EN to reject misaligned
// half/word stores and the reserved size code with a done+err pulse.
//
// Ports:
//   clk        in  1   system clock, rising edge
//   reset      in  1   asynchronous active-high reset
//   start      in  1   request, sampled only in IDLE
//   ss_ctrl    in  2   store size code
//   addr       in  32  byte address
//   data_in    in  32  right-aligned, zero-extended store value
//   mem_rdata  in  32  memory read data
//   mem_addr   out 32  word-aligned memory address (held in IDLE)
//   mem_wr     out 1   one-cycle write strobe
//   mem_wdata  out 32  merged write word
//   busy       out 1   high in READ and WRITE
//   done       out 1   one-cycle completion pulse
//   err        out 1   one-cycle error pulse (0 without the alignment check)

module store_merge
    import store_merge_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  ss_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         ss_q, ss_d;
    logic [1:0]         lane_q, lane_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        merge_q, merge_d;
    logic               wr_q, wr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               req_fault;
    logic [31:0]        merged;

    store_lane_merge u_lane_merge (
        .old_word (mem_rdata),
        .data     (data_q),
        .ss_ctrl  (ss_q),
        .addr_lo  (lane_q),
        .merged   (merged)
    );

`ifdef STORE_MERGE_ALIGN_CHECK_EN
    logic err_q;

    // Requests that must never touch memory when the check is built in.
    assign req_fault = (ss_ctrl == SS_RSVD)
                    || (ss_ctrl == SS_HALF && addr[0])
                    || (ss_ctrl == SS_WORD && addr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else
            err_q <= (state_q == ST_IDLE) && start && req_fault;
    end

    assign err = err_q;
`else
    assign req_fault = 1'b0;
    assign err       = 1'b0;
`endif

    // State and capture registers. Every output is a flop so nothing
    // reaches the ports combinationally from an input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ss_q    <= SS_WORD;
            lane_q  <= 2'b00;
            data_q  <= '0;
            addr_q  <= '0;
            merge_q <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ss_q    <= ss_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            merge_q <= merge_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. Output flops are loaded with the value they must
    // show in the state being entered, so wr/done/busy line up with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ss_d    = ss_q;
        lane_d  = lane_q;
        data_d  = data_q;
        addr_d  = addr_q;
        merge_d = merge_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ss_d   = ss_ctrl;
                    lane_d = addr[1:0];
                    data_d = data_in;
                    addr_d = {addr[31:2], 2'b00};
                    if (req_fault) begin
                        done_d = 1'b1;
                    end else begin
                        case (ss_ctrl)
                            SS_WORD: begin
                                merge_d = data_in;
                                wr_d    = 1'b1;
                                state_d = ST_WRITE;
                            end
                            SS_HALF, SS_BYTE: begin
                                cnt_d   = CNT_W'(MEM_LAT);
                                state_d = ST_READ;
                            end
                            default: done_d = 1'b1;
                        endcase
                    end
                end
            end
            ST_READ: begin
                // cnt_q == 1 marks the last read cycle; mem_rdata is valid now.
                if (cnt_q == CNT_W'(1)) begin
                    merge_d = merged;
                    wr_d    = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WRITE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign mem_addr  = addr_q;
    assign mem_wr    = wr_q;
    assign mem_wdata = merge_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_store_merge.sv
// tb_store_merge
//
// Directed bench for store_merge. Two instances share the data inputs:
// u_dut1 (MEM_LAT=1) and u_dut3 (MEM_LAT=3), each with its own start.
// Expected memory writes are queued as requests are issued and popped by a
// per-instance write monitor; cycle-level flags are checked inline.

module tb_store_merge;
    import store_merge_pkg::*;

    logic        clk;
    logic        reset;
    logic        start1, start3;
    logic [1:0]  ss_ctrl;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] mem_rdata;

    logic [31:0] mem_addr1, mem_wdata1, mem_addr3, mem_wdata3;
    logic        mem_wr1, busy1, done1, err1;
    logic        mem_wr3, busy3, done3, err3;

    int vectors;
    int miscompares;

    logic [63:0] exp_q1[$];
    logic [63:0] exp_q3[$];

    store_merge #(.MEM_LAT(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .ss_ctrl   (ss_ctrl),
        .addr      (addr),
        .data_in   (data_in),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr1),
        .mem_wr    (mem_wr1),
        .mem_wdata (mem_wdata1),
        .busy      (busy1),
        .done      (done1),
        .err       (err1)
    );

    store_merge #(.MEM_LAT(3)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .start     (start3),
        .ss_ctrl   (ss_ctrl),
        .addr      (addr),
        .data_in   (data_in),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr3),
        .mem_wr    (mem_wr3),
        .mem_wdata (mem_wdata3),
        .busy      (busy3),
        .done      (done3),
        .err       (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] ss, input logic [31:0] a,
                                  input logic [31:0] d);
        ss_ctrl = ss;
        addr    = a;
        data_in = d;
    endtask

    // Write monitors: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (!reset && mem_wr1 === 1'b1) begin
            if (exp_q1.size() == 0) begin
                check_output("dut1_unexpected_write", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q1.pop_front();
                check_output("dut1_wr_addr", mem_addr1, e[63:32]);
                check_output("dut1_wr_data", mem_wdata1, e[31:0]);
            end
        end
        if (!reset && mem_wr3 === 1'b1) begin
            if (exp_q3.size() == 0) begin
                check_output("dut3_unexpected_write", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q3.pop_front();
                check_output("dut3_wr_addr", mem_addr3, e[63:32]);
                check_output("dut3_wr_data", mem_wdata3, e[31:0]);
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start1      = 1'b0;
        start3      = 1'b0;
        mem_rdata   = 32'h1122_3344;
        apply_stimulus(SS_WORD, 32'h0, 32'h0);
        tick();
        tick();

        // Reset values
        check_output("rst_mem_addr", mem_addr1, 32'h0);
        check_output("rst_mem_wdata", mem_wdata1, 32'h0);
        check_output("rst_flags", {28'h0, mem_wr1, busy1, done1, err1}, 32'h0);
        reset = 1'b0;
        tick();

        $display("[TB] word store");
        apply_stimulus(SS_WORD, 32'h100, 32'hDEAD_BEEF);
        start1 = 1'b1;
        exp_q1.push_back({32'h100, 32'hDEAD_BEEF});
        tick();
        start1 = 1'b0;
        check_output("word_c1_wr_busy_done", {30'h0, mem_wr1, busy1}, 32'h3);
        check_output("word_c1_done", {31'h0, done1}, 32'h0);
        tick();
        check_output("word_c2_done_busy_wr", {29'h0, done1, busy1, mem_wr1}, 32'h4);
        tick();
        check_output("word_c3_done", {31'h0, done1}, 32'h0);

        $display("[TB] byte store lane 3");
        apply_stimulus(SS_BYTE, 32'h103, 32'h0000_00AB);
        start1 = 1'b1;
        exp_q1.push_back({32'h100, 32'hAB22_3344});
        tick();
        start1 = 1'b0;
        check_output("byte_c1_busy_wr", {30'h0, busy1, mem_wr1}, 32'h2);
        tick();
        check_output("byte_c2_wr", {31'h0, mem_wr1}, 32'h1);
        tick();
        check_output("byte_c3_done_busy", {30'h0, done1, busy1}, 32'h2);
        tick();

        $display("[TB] half store high lane, start during READ ignored");
        apply_stimulus(SS_HALF, 32'h102, 32'h0000_CAFE);
        start1 = 1'b1;
        exp_q1.push_back({32'h100, 32'hCAFE_3344});
        tick();
        apply_stimulus(SS_WORD, 32'h200, 32'h5555_5555);
        tick();
        start1 = 1'b0;
        check_output("half_c2_wr", {31'h0, mem_wr1}, 32'h1);
        tick();
        check_output("half_c3_done", {31'h0, done1}, 32'h1);
        tick();
        check_output("half_c4_idle", {29'h0, busy1, mem_wr1, done1}, 32'h0);

        $display("[TB] MEM_LAT=3 byte store lane 1");
        apply_stimulus(SS_BYTE, 32'h101, 32'h0000_00FF);
        start3 = 1'b1;
        exp_q3.push_back({32'h100, 32'h1122_FF44});
        for (int c = 1; c <= 5; c++) begin
            tick();
            start3 = 1'b0;
            check_output($sformatf("lat3_c%0d_wr", c), {31'h0, mem_wr3}, {31'h0, c == 4});
            check_output($sformatf("lat3_c%0d_done", c), {31'h0, done3}, {31'h0, c == 5});
        end
        tick();

        $display("[TB] reset during READ");
        apply_stimulus(SS_BYTE, 32'h102, 32'h0000_0077);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check_output("rstmid_busy_before", {31'h0, busy1}, 32'h1);
        reset = 1'b1;
        #1;
        check_output("rstmid_busy_wr", {30'h0, busy1, mem_wr1}, 32'h0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_output("rstmid_no_done", {30'h0, done1, mem_wr1}, 32'h0);
        end
        apply_stimulus(SS_WORD, 32'h40, 32'h1234_5678);
        start1 = 1'b1;
        exp_q1.push_back({32'h40, 32'h1234_5678});
        tick();
        start1 = 1'b0;
        tick();
        check_output("post_rst_word_done", {31'h0, done1}, 32'h1);
        tick();

        $display("[TB] reserved size code");
        apply_stimulus(SS_RSVD, 32'h80, 32'h0);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
`ifdef STORE_MERGE_ALIGN_CHECK_EN
        check_output("rsvd_done_err", {30'h0, done1, err1}, 32'h3);
`else
        check_output("rsvd_done_err", {30'h0, done1, err1}, 32'h2);
`endif
        check_output("rsvd_busy_wr", {30'h0, busy1, mem_wr1}, 32'h0);
        tick();

        $display("[TB] misaligned half at 0x101");
        apply_stimulus(SS_HALF, 32'h101, 32'h0000_CAFE);
        start1 = 1'b1;
`ifdef STORE_MERGE_ALIGN_CHECK_EN
        tick();
        start1 = 1'b0;
        check_output("mis_c1_done_err", {30'h0, done1, err1}, 32'h3);
        check_output("mis_c1_busy_wr", {30'h0, busy1, mem_wr1}, 32'h0);
        tick();
        check_output("mis_c2_idle", {29'h0, busy1, mem_wr1, done1}, 32'h0);
`else
        exp_q1.push_back({32'h100, 32'h1122_CAFE});
        tick();
        start1 = 1'b0;
        check_output("mis_c1_err", {31'h0, err1}, 32'h0);
        tick();
        check_output("mis_c2_wr", {31'h0, mem_wr1}, 32'h1);
        tick();
        check_output("mis_c3_done_err", {30'h0, done1, err1}, 32'h2);
`endif
        tick();
        tick();

        check_output("dut1_pending_writes", exp_q1.size(), 32'd0);
        check_output("dut3_pending_writes", exp_q3.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
